// File: rtl/sensor_scan_ctrl.sv
// sensor_scan_ctrl: round-robin scan of four sensor channels through a shared change detector
module sensor_scan_ctrl #(
    parameter int CP_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [3:0]                    chan_mask,
    input  logic [3:0]                    req,
    input  logic [31:0]                   sensor_data,
    output logic [3:0]                    ack,
    output logic [7:0]                    cp_data,
    output logic [1:0]                    cp_check,
    input  logic                          cp_q,
    input  logic [1:0]                    cp_q1,
    output logic                          evt_valid,
    output logic [1:0]                    evt_chan,
    output logic [7:0]                    evt_data,
    input  logic                          evt_ready,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count,
    output logic                          overflow,
    output logic                          chan_err,
    input  logic                          clr_sticky,
    output logic                          busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = CP_LAT > 0 ? $clog2(CP_LAT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t          state, state_d;
    logic [1:0]      ptr, gsel;
    logic            found, start, capture;
    logic [3:0]      elig;
    logic [LW-1:0]   cnt;
    logic [9:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wp, rp;
    logic            full, push_req, push, pop;

    assign elig     = req & chan_mask;
    assign start    = (state == IDLE) & enable & found;
    assign capture  = (state != IDLE) & (cnt == '0);
    assign full     = evt_count == CW'(FIFO_DEPTH);
    assign push_req = capture & cp_q;
    assign pop      = evt_valid & evt_ready;
    assign push     = push_req & (~full | pop);
    assign evt_valid = evt_count != '0;
    assign {evt_chan, evt_data} = mem[rp];
    assign busy     = state != IDLE;

    // pick the first eligible channel after the last one granted
    always_comb begin
        gsel  = ptr;
        found = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            if (elig[ptr + 2'(k)]) begin
                found = 1'b1;
                gsel  = ptr + 2'(k);
            end
        end
    end

    // next state: issue on grant, wait out the detector latency, capture, back to idle
    always_comb begin
        state_d = state;
        if (state == IDLE)
            state_d = start ? ISSUE : IDLE;
        else
            state_d = capture ? IDLE : WAIT;
    end

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    // grant bookkeeping and the held detector inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr      <= 2'd3;
            ack      <= '0;
            cp_data  <= '0;
            cp_check <= '0;
            cnt      <= '0;
        end else begin
            ack <= start ? 4'b0001 << gsel : 4'b0000;
            cnt <= start ? LW'(CP_LAT) : (cnt != '0 ? cnt - LW'(1) : cnt);
            if (start) begin
                ptr      <= gsel;
                cp_data  <= sensor_data[8*gsel +: 8];
                cp_check <= gsel;
            end
        end
    end

    // event storage; contents need no reset since occupancy gates visibility
    always_ff @(posedge clk) begin
        if (push)
            mem[wp] <= {cp_check, cp_data};
    end

    // event pointers, occupancy and sticky error flags (a new error beats a clear)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp        <= '0;
            rp        <= '0;
            evt_count <= '0;
            overflow  <= 1'b0;
            chan_err  <= 1'b0;
        end else begin
            wp        <= push ? wp + AW'(1) : wp;
            rp        <= pop ? rp + AW'(1) : rp;
            evt_count <= evt_count + CW'(push) - CW'(pop);
            overflow  <= (push_req & full & ~pop) | (overflow & ~clr_sticky);
            chan_err  <= (capture & cp_q & (cp_q1 != cp_check)) | (chan_err & ~clr_sticky);
        end
    end
endmodule

// File: tb/tb_sensor_scan_ctrl.sv
// tb_sensor_scan_ctrl: directed and random scans checked against a transaction-level model
module tb_sensor_scan_ctrl;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n, enable, evt_ready, clr_sticky, cp_q, evt_valid, overflow, chan_err, busy;
    logic [3:0]  chan_mask, req, ack;
    logic [31:0] sensor_data;
    logic [7:0]  cp_data, evt_data;
    logic [1:0]  cp_check, cp_q1, evt_chan;
    logic [2:0]  evt_count;

    int checks = 0;
    int errors = 0;

    logic [9:0] mq[$];
    bit         ovf_m, err_m;
    int         ptr_m;
    int         prev;

    sensor_scan_ctrl #(.CP_LAT(2), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .chan_mask(chan_mask), .req(req),
        .sensor_data(sensor_data), .ack(ack), .cp_data(cp_data), .cp_check(cp_check),
        .cp_q(cp_q), .cp_q1(cp_q1), .evt_valid(evt_valid), .evt_chan(evt_chan),
        .evt_data(evt_data), .evt_ready(evt_ready), .evt_count(evt_count),
        .overflow(overflow), .chan_err(chan_err), .clr_sticky(clr_sticky), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ack", ack, 0);
        chk("rst_cp_data", cp_data, 0);
        chk("rst_cp_check", cp_check, 0);
        chk("rst_evt_valid", evt_valid, 0);
        chk("rst_evt_count", evt_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_chan_err", chan_err, 0);
        chk("rst_busy", busy, 0);
    endtask

    // one clock edge: advance the event queue model, then compare the queue outputs
    task automatic tick(input bit push, input int ch, input logic [7:0] d, input bit err);
        bit pop, drop;
        @(posedge clk);
        pop  = (mq.size() > 0) && evt_ready;
        drop = 1'b0;
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < DEPTH) mq.push_back({2'(ch), d});
            else drop = 1'b1;
        end
        ovf_m = drop | (ovf_m & ~clr_sticky);
        err_m = err | (err_m & ~clr_sticky);
        #1;
        chk("evt_valid", evt_valid, mq.size() != 0);
        chk("evt_count", evt_count, mq.size());
        if (mq.size() > 0) chk("evt_head", {evt_chan, evt_data}, mq[0]);
        chk("overflow", overflow, ovf_m);
        chk("chan_err", chan_err, err_m);
    endtask

    function automatic int absd(input int a, input int b);
        return a > b ? a - b : b - a;
    endfunction

    // one scan opportunity; the bench plays the detector, driving its real answer only
    // in the cycle before the capture edge
    task automatic txn(input logic [3:0] r, input logic [3:0] m, input logic [31:0] sd,
                       input bit keep, input bit frc, input bit fq, input logic [1:0] fq1,
                       input bit rdy3, input bit abort);
        int ch;
        bit q;
        logic [1:0] q1;
        logic [7:0] d;
        req = r;
        chan_mask = m;
        sensor_data = sd;
        ch = -1;
        if (enable)
            for (int k = 1; k <= 4; k++)
                if (ch < 0 && r[(ptr_m + k) % 4] && m[(ptr_m + k) % 4]) ch = (ptr_m + k) % 4;
        tick(0, 0, 0, 0);
        if (ch < 0) begin
            chk("no_ack", ack, 0);
            chk("idle_busy", busy, 0);
            if (!keep) req = 0;
            return;
        end
        d = sd[8*ch +: 8];
        chk("ack_e0", ack, 32'd1 << ch);
        chk("cp_data_e0", cp_data, d);
        chk("cp_check_e0", cp_check, ch);
        chk("busy_e0", busy, 1);
        ptr_m = ch;
        if (!keep) req = 0;
        q  = frc ? fq : (absd(d, prev) > 1);
        q1 = frc ? fq1 : 2'(ch);
        prev = d;
        cp_q  = ~q;
        cp_q1 = ~q1;
        tick(0, 0, 0, 0);
        chk("ack_pulse", ack, 0);
        chk("busy_e1", busy, 1);
        chk("cp_data_hold", cp_data, d);
        tick(0, 0, 0, 0);
        chk("busy_e2", busy, 1);
        if (abort) begin
            reset_n = 0;
            #1;
            chk_reset_outputs();
            mq.delete();
            ovf_m = 0;
            err_m = 0;
            ptr_m = 3;
            req = 0;
            #2 reset_n = 1;
            return;
        end
        cp_q  = q;
        cp_q1 = q1;
        if (rdy3) evt_ready = 1;
        tick(q, ch, d, q && (q1 != 2'(ch)));
        if (rdy3) evt_ready = 0;
        cp_q  = ~q;
        cp_q1 = ~q1;
        chk("busy_e3", busy, 0);
    endtask

    task automatic drain();
        evt_ready = 1;
        repeat (5) tick(0, 0, 0, 0);
        evt_ready = 0;
    endtask

    initial begin
        reset_n = 0; enable = 1; chan_mask = 4'hF; req = 0; sensor_data = 0;
        evt_ready = 0; clr_sticky = 0; cp_q = 0; cp_q1 = 0;
        ovf_m = 0; err_m = 0; ptr_m = 3; prev = 0;
        #2;
        chk_reset_outputs();
        #6 reset_n = 1;
        // first sample on a fresh detector is a change; a step of 1 is not
        txn(4'b0010, 4'hF, 32'h0000_1000, 0, 0, 0, 0, 0, 0);
        txn(4'b0010, 4'hF, 32'h0000_1100, 0, 0, 0, 0, 0, 0);
        txn(4'b0010, 4'hF, 32'h0000_2000, 0, 0, 0, 0, 0, 0);
        drain();
        // continuously held requests: rotation, back-to-back grants, masked channel skipped
        evt_ready = 1;
        for (int i = 0; i < 5; i++) txn(4'hF, 4'hF, $urandom(), 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) txn(4'hF, 4'b1011, $urandom(), 1, 0, 0, 0, 0, 0);
        req = 0;
        evt_ready = 0;
        drain();
        // fill past capacity, clear the sticky, then push and pop together while full
        for (int i = 0; i < 5; i++) txn(4'b0001, 4'hF, (i % 2) ? 32'h80 : 32'h01, 0, 1, 1, 2'd0, 0, 0);
        clr_sticky = 1;
        tick(0, 0, 0, 0);
        clr_sticky = 0;
        txn(4'b0001, 4'hF, 32'h55, 0, 1, 1, 2'd0, 1, 0);
        drain();
        // detector reports the wrong channel during a ch3 scan
        txn(4'b1000, 4'hF, 32'h7700_0000, 0, 1, 1, 2'd0, 0, 0);
        // scanning disabled
        enable = 0;
        txn(4'b0100, 4'hF, 32'h0012_0000, 0, 0, 0, 0, 0, 0);
        enable = 1;
        // reset in the middle of a scan, then rotation restarts at ch0
        txn(4'b0100, 4'hF, 32'h0099_0000, 0, 0, 0, 0, 0, 1);
        txn(4'hF, 4'hF, 32'h4433_2211, 0, 0, 0, 0, 0, 0);
        // random traffic
        for (int i = 0; i < 60; i++) begin
            enable     = ($urandom_range(0, 7) != 0);
            evt_ready  = $urandom_range(0, 1);
            clr_sticky = ($urandom_range(0, 9) == 0);
            txn(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom(), 0,
                $urandom_range(0, 4) == 0, $urandom_range(0, 1), 2'($urandom_range(0, 3)), 0, 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
